// File: rtl/uart_digit_rx.sv
`timescale 1ns/1ps
// uart_digit_rx
//
// Receives 8N1 UART characters (LSB first, idle high) and assembles
// fixed-length lines of ASCII digits. A line is committed to 'digits' when a
// carriage return arrives with exactly NUM_CHARS digits buffered. Backspace
// removes the last buffered digit. Any other byte, or a malformed line,
// flags an error and restarts the line.
//
// Parameters
//   CLKS_PER_BIT : clk1mhz cycles per UART bit (104 -> 9600 baud at 1 MHz)
//   NUM_CHARS    : digits per line, 1..15
//
// Ports
//   clk1mhz  in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   rxd      in   asynchronous UART line
//   enable   in   capture mode; low holds the receiver idle
//   clear    in   synchronous flush of the line buffer and outputs
//   digits   out  last accepted line, char 0 (first received) in [7:0]
//   valid    out  one-cycle pulse when digits is updated
//   err      out  one-cycle pulse on a framing or line-format error
//   char_cnt out  digits buffered in the current line

module uart_digit_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int NUM_CHARS    = 6
) (
    input  logic                   clk1mhz,
    input  logic                   reset,
    input  logic                   rxd,
    input  logic                   enable,
    input  logic                   clear,
    output logic [8*NUM_CHARS-1:0] digits,
    output logic                   valid,
    output logic                   err,
    output logic [3:0]             char_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Baud counter is 10 bits so CLKS_PER_BIT up to 1023 never wraps
    // inside a bit period.
    localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [3:0] MAX_CNT   = 4'(NUM_CHARS);

    logic                   rxd_meta;
    logic                   rxd_sync;
    state_t                 state;
    state_t                 state_next;
    logic [9:0]             baud_cnt;
    logic [9:0]             baud_cnt_next;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_idx_next;
    logic [7:0]             shift;
    logic [7:0]             shift_next;
    logic                   byte_done;
    logic                   stop_ok;
    logic                   is_digit;
    logic [8*NUM_CHARS-1:0] buffer;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset release never looks like a start bit.
    always_ff @(posedge clk1mhz or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Bit FSM registers.
    always_ff @(posedge clk1mhz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    // Bit FSM next state. The start bit is checked at its midpoint, and
    // every later sample is a whole bit period after the previous one, so
    // all samples land near bit centres. byte_done marks the stop-bit
    // sample; clear and a dropped enable abort the frame silently.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 10'd1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        byte_done     = 1'b0;
        stop_ok       = 1'b0;
        if (clear || !enable) begin
            state_next    = IDLE;
            baud_cnt_next = '0;
            bit_idx_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    if (!rxd_sync) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt_next = '0;
                        bit_idx_next  = '0;
                        state_next    = rxd_sync ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt_next = '0;
                        shift_next    = {rxd_sync, shift[7:1]};
                        bit_idx_next  = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt_next = '0;
                        byte_done     = 1'b1;
                        stop_ok       = rxd_sync;
                        state_next    = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign is_digit = (shift >= 8'h30) && (shift <= 8'h39);

    // Line assembly. Acts once per completed frame; valid and err are
    // registered so they pulse the cycle after the stop-bit sample and are
    // mutually exclusive by construction. Backspace only moves the count
    // back; the stale slot is overwritten by the next digit.
    always_ff @(posedge clk1mhz or negedge reset) begin
        if (!reset) begin
            buffer   <= '0;
            digits   <= '0;
            char_cnt <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (clear) begin
                buffer   <= '0;
                digits   <= '0;
                char_cnt <= '0;
            end else if (byte_done) begin
                if (!stop_ok) begin
                    err <= 1'b1;
                end else if (is_digit && (char_cnt < MAX_CNT)) begin
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        if (char_cnt == 4'(i)) begin
                            buffer[8*i +: 8] <= shift;
                        end
                    end
                    char_cnt <= char_cnt + 4'd1;
                end else if (shift == 8'h08) begin
                    if (char_cnt != 4'd0) begin
                        char_cnt <= char_cnt - 4'd1;
                    end
                end else if ((shift == 8'h0D) && (char_cnt == MAX_CNT)) begin
                    digits   <= buffer;
                    valid    <= 1'b1;
                    char_cnt <= '0;
                end else begin
                    err      <= 1'b1;
                    char_cnt <= '0;
                end
            end
        end
    end

endmodule
